pic_nchan: RTL and testbench

Parametrised 8259A-compatible programmable interrupt controller for the V20 PC core, successor to the fixed two-input `pic`. It accepts `NUM_IRQ` interrupt lines, latches them in IRR, applies IMR masking and ISR fixed-priority nesting, and drives the CPU INTR pin. It services the two-cycle INTA handshake, handles EOI commands, and answers the standard ICW/OCW port accesses on the internal CPU bus.

---
 rtl/pic_nchan.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_pic_nchan.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pic_nchan.sv
// -----------------------------------------------------------------------------
// pic_nchan -- 8259A-compatible programmable interrupt controller, NUM_IRQ
// request lines (1..8), single mode, fixed priority (IRQ0 highest).
//
// Requests are latched into IRR, filtered by IMR, nested against ISR and
// presented to the CPU on oInt. A two-pulse INTA handshake moves the winning
// request from IRR to ISR and returns {vector base, channel} on oData. The
// standard ICW1/ICW2/ICW4 and OCW1/OCW2/OCW3 port accesses are decoded at
// IO_BASE (A1=0) and IO_BASE+1 (A1=1).
//
// Optional feature macro: PIC_LEVEL_TRIG_EN
//   defined   : ICW1 LTIM=1 switches every channel to level-triggered mode.
//   undefined : LTIM is stored but edge-triggered mode always applies.
//
// Bus handshake: iWr is a one-cycle strobe and the write takes effect at the
// clock edge that samples it; iRd is a level and read data is combinational
// for as long as it is held; iIntAck is a level per INTA bus cycle and only
// its rising edges (and the final falling edge) advance the INTA sequence.
//
// Ports
//   iClk      in   bus clock
//   iRstN     in   synchronous reset, active low
//   iAddr     in   CPU address [19:0], bits [15:0] decoded
//   iData     in   CPU write data
//   iWr       in   IO write strobe (one-cycle pulse)
//   iRd       in   IO read strobe (level)
//   iIrq      in   request lines, synchronous to iClk
//   iIntAck   in   high for the duration of each INTA bus cycle
//   oInt      out  INTR to the CPU (registered)
//   oSel      out  read-mux select (combinational)
//   oData     out  register read data or interrupt vector (combinational)
//   oDbg      out  debug state {ltim, init_state[1:0], inta_state[1:0]}
// -----------------------------------------------------------------------------
module pic_nchan #(
  parameter int          NUM_IRQ    = 8,
  parameter logic [15:0] IO_BASE    = 16'h0020,
  parameter logic [7:0]  VECTOR_RST = 8'h08
) (
  input  logic               iClk,
  input  logic               iRstN,
  input  logic [19:0]        iAddr,
  input  logic [7:0]         iData,
  input  logic               iWr,
  input  logic               iRd,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic               iIntAck,
  output logic               oInt,
  output logic               oSel,
  output logic [7:0]         oData,
  output logic [4:0]         oDbg
);

  // Mask of implemented channels; all internal vectors are 8 bits wide and
  // unimplemented positions are held at zero.
  localparam logic [15:0] IMPL_W = (16'd1 << NUM_IRQ) - 16'd1;
  localparam logic [7:0]  IMPL   = IMPL_W[7:0];

  typedef enum logic [1:0] {
    READY  = 2'd0,
    W_ICW2 = 2'd1,
    W_ICW4 = 2'd2
  } init_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK1 = 2'd1,
    ACK2 = 2'd2
  } inta_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  init_t      init_q,   init_d;
  inta_t      inta_q,   inta_d;
  logic [7:0] imr_q,    imr_d;
  logic [7:0] irr_q,    irr_d;
  logic [7:0] isr_q,    isr_d;
  logic [7:0] prev_q,   prev_d;     // request-line history for edge detect
  logic [4:0] vb_q,     vb_d;       // vector base (ICW2 bits 7:3)
  logic [2:0] ackn_q,   ackn_d;     // channel latched at first INTA edge
  logic       rd_isr_q, rd_isr_d;   // 0: A1=0 reads IRR, 1: reads ISR
  logic       ltim_q,   ltim_d;
  logic       ic4_q,    ic4_d;
  logic       int_q,    int_d;
  logic       ack_prev_q;

  // ---------------------------------------------------------------------------
  // Decode and priority
  // ---------------------------------------------------------------------------
  logic [7:0] irq8;
  logic       hit, a1, wr;
  logic       is_icw1, is_ocw2, is_ocw3, is_data;
  logic [7:0] req;
  logic [2:0] pend, isr_top;
  logic       pend_valid, isr_any;
  logic       ack_rise, ack_fall, take;
  logic       level;
  logic       unused_addr;

  always_comb begin
    irq8 = 8'h00;
    for (int i = 0; i < NUM_IRQ; i++) irq8[i] = iIrq[i];
  end

  assign hit     = (iAddr[15:1] == IO_BASE[15:1]);
  assign a1      = iAddr[0];
  assign wr      = iWr & hit;
  assign is_icw1 = wr & ~a1 & iData[4];
  assign is_ocw2 = wr & ~a1 & (iData[4:3] == 2'b00);
  assign is_ocw3 = wr & ~a1 & (iData[4:3] == 2'b01);
  assign is_data = wr & a1;

  assign unused_addr = ^iAddr[19:16];

  assign req = irr_q & ~imr_q & IMPL;

  // Lowest set index wins: scan from the top so the last match is the lowest.
  always_comb begin
    pend       = 3'd0;
    pend_valid = 1'b0;
    isr_top    = 3'd0;
    isr_any    = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (req[i]) begin
        pend       = 3'(i);
        pend_valid = 1'b1;
      end
      if (isr_q[i]) begin
        isr_top = 3'(i);
        isr_any = 1'b1;
      end
    end
  end

  assign ack_rise = iIntAck & ~ack_prev_q;
  assign ack_fall = ~iIntAck & ack_prev_q;
  assign take     = (inta_q == IDLE) & ack_rise;

`ifdef PIC_LEVEL_TRIG_EN
  assign level = ltim_q;
`else
  assign level = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic [7:0] irr_set, irr_clr, isr_set, isr_clr;

  always_comb begin
    init_d   = init_q;
    inta_d   = inta_q;
    imr_d    = imr_q;
    vb_d     = vb_q;
    ackn_d   = ackn_q;
    rd_isr_d = rd_isr_q;
    ltim_d   = ltim_q;
    ic4_d    = ic4_q;
    prev_d   = irq8;
    irr_clr  = 8'h00;
    isr_set  = 8'h00;
    isr_clr  = 8'h00;

    // INTA sequence. The first edge commits the acknowledge; with nothing
    // pending it answers spurious channel 7 and leaves ISR/IRR alone.
    unique case (inta_q)
      IDLE: begin
        if (ack_rise) begin
          inta_d = ACK1;
          if (pend_valid) begin
            ackn_d  = pend;
            isr_set = 8'b1 << pend;
            irr_clr = 8'b1 << pend;
          end else begin
            ackn_d  = 3'd7;
          end
        end
      end
      ACK1:    if (ack_rise) inta_d = ACK2;
      ACK2:    if (ack_fall) inta_d = IDLE;
      default: inta_d = IDLE;
    endcase

    if (is_ocw2) begin
      if (iData == 8'h20 && isr_any) isr_clr = isr_clr | (8'b1 << isr_top);
      if (iData[7:3] == 5'b01100)    isr_clr = isr_clr | (8'b1 << iData[2:0]);
    end

    if (is_ocw3) begin
      if (iData[1:0] == 2'b10) rd_isr_d = 1'b0;
      if (iData[1:0] == 2'b11) rd_isr_d = 1'b1;
    end

    if (is_data) begin
      unique case (init_q)
        W_ICW2: begin
          vb_d   = iData[7:3];
          init_d = ic4_q ? W_ICW4 : READY;
        end
        W_ICW4:  init_d = READY;
        default: imr_d  = iData;
      endcase
    end

    // Edge mode latches 0->1 transitions; level mode latches any high line and
    // drops requests whose line went low before they were serviced.
    if (level) begin
      irr_set = irq8;
      irr_clr = irr_clr | (~irq8 & ~isr_q);
    end else begin
      irr_set = irq8 & ~prev_q;
    end

    // Set wins over clear on the same bit; EOI and INTA both apply.
    irr_d = ((irr_q & ~irr_clr) | irr_set) & IMPL;
    isr_d = ((isr_q & ~isr_clr) | isr_set) & IMPL;

    // oInt is withheld while an acknowledge is in flight, including the cycle
    // the first INTA edge is taken.
    int_d = pend_valid & (~isr_any | (pend < isr_top)) & (inta_q == IDLE) & ~take;

    // ICW1 restarts initialisation and overrides every other update.
    if (is_icw1) begin
      imr_d    = 8'h00;
      isr_d    = 8'h00;
      irr_d    = 8'h00;
      prev_d   = 8'h00;
      rd_isr_d = 1'b0;
      ltim_d   = iData[3];
      ic4_d    = iData[0];
      init_d   = W_ICW2;
      int_d    = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      init_q     <= READY;
      inta_q     <= IDLE;
      imr_q      <= 8'h00;
      irr_q      <= 8'h00;
      isr_q      <= 8'h00;
      prev_q     <= irq8;
      vb_q       <= VECTOR_RST[7:3];
      ackn_q     <= 3'd7;
      rd_isr_q   <= 1'b0;
      ltim_q     <= 1'b0;
      ic4_q      <= 1'b0;
      int_q      <= 1'b0;
      // Track the live INTA level so a reset inside a held INTA cycle does
      // not produce a phantom rising edge afterwards.
      ack_prev_q <= iIntAck;
    end else begin
      init_q     <= init_d;
      inta_q     <= inta_d;
      imr_q      <= imr_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      prev_q     <= prev_d;
      vb_q       <= vb_d;
      ackn_q     <= ackn_d;
      rd_isr_q   <= rd_isr_d;
      ltim_q     <= ltim_d;
      ic4_q      <= ic4_d;
      int_q      <= int_d;
      ack_prev_q <= iIntAck;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic [2:0] vec_chan;

  // Before the first edge is taken the vector previews the channel that edge
  // will latch, so oData is meaningful from the first INTA cycle on.
  assign vec_chan = (inta_q != IDLE) ? ackn_q : (pend_valid ? pend : 3'd7);

  always_comb begin
    oData = 8'h00;
    if (iIntAck)         oData = {vb_q, vec_chan};
    else if (iRd && hit) oData = a1 ? (imr_q | ~IMPL) : (rd_isr_q ? isr_q : irr_q);
  end

  assign oSel = (iRd & hit) | iIntAck;
  assign oInt = int_q;
  assign oDbg = {ltim_q, init_q, inta_q};

endmodule

// File: tb/tb_pic_nchan.sv
// -----------------------------------------------------------------------------
// tb_pic_nchan -- self-checking bench for pic_nchan.
// Main instance u_dut runs at NUM_IRQ=8 against a register-level model of the
// controller; u_dut2 (NUM_IRQ=2) shares the CPU bus to cover unimplemented-bit
// readback and channel limits. Inputs change 1 time unit after the rising
// clock edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pic_nchan;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [19:0] addr  = 20'h0;
  logic [7:0]  data  = 8'h0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic [7:0]  irq   = 8'h0;
  logic [1:0]  irq2  = 2'h0;
  logic        ack   = 1'b0;

  logic        int_o,  sel_o,  int2_o, sel2_o;
  logic [7:0]  dout,   dout2;
  logic [4:0]  dbg,    dbg2;

  pic_nchan #(.NUM_IRQ(8)) u_dut (
    .iClk(clk), .iRstN(rst_n), .iAddr(addr), .iData(data), .iWr(wr), .iRd(rd),
    .iIrq(irq), .iIntAck(ack), .oInt(int_o), .oSel(sel_o), .oData(dout), .oDbg(dbg)
  );

  pic_nchan #(.NUM_IRQ(2)) u_dut2 (
    .iClk(clk), .iRstN(rst_n), .iAddr(addr), .iData(data), .iWr(wr), .iRd(rd),
    .iIrq(irq2), .iIntAck(1'b0), .oInt(int2_o), .oSel(sel2_o), .oData(dout2), .oDbg(dbg2)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_vb;
  bit         m_rd_isr, m_ic4;
  int         m_init;   // 0 ready, 1 expecting ICW2, 2 expecting ICW4

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 8;
  endfunction

  function automatic logic exp_int();
    int p, t;
    p = lowest(m_irr & ~m_imr);
    t = lowest(m_isr);
    return (p < 8) && (p < t);
  endfunction

  task automatic model_reset();
    m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00;
    m_vb = 5'd1;   m_rd_isr = 0;  m_ic4 = 0; m_init = 0;
  endtask

  task automatic model_write(input bit a1, input logic [7:0] d);
    int t;
    if (!a1 && d[4]) begin
      m_irr = 0; m_isr = 0; m_imr = 0; m_rd_isr = 0;
      m_ic4 = d[0]; m_init = 1;
    end else if (!a1 && d[4:3] == 2'b00) begin
      if (d == 8'h20) begin
        t = lowest(m_isr);
        if (t < 8) m_isr[t] = 1'b0;
      end else if (d[7:3] == 5'b01100) begin
        m_isr[d[2:0]] = 1'b0;
      end
    end else if (!a1 && d[4:3] == 2'b01) begin
      if (d[1:0] == 2'b10) m_rd_isr = 0;
      if (d[1:0] == 2'b11) m_rd_isr = 1;
    end else if (a1) begin
      if (m_init == 1) begin
        m_vb = d[7:3];
        m_init = m_ic4 ? 2 : 0;
      end else if (m_init == 2) begin
        m_init = 0;
      end else begin
        m_imr = d;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wr_reg(input bit a1, input logic [7:0] d);
    adv();
    addr = 20'h00020 + 20'(a1);
    data = d;
    wr   = 1'b1;
    adv();
    wr   = 1'b0;
    model_write(a1, d);
  endtask

  logic [7:0] rd_val, rd2_val;

  task automatic rd_reg(input bit a1);
    adv();
    addr = 20'h00020 + 20'(a1);
    rd   = 1'b1;
    smp();
    rd_val  = dout;
    rd2_val = dout2;
    chk("rd_sel", {7'd0, sel_o}, 8'h01);
    adv();
    rd   = 1'b0;
  endtask

  task automatic read_chk(input string tag, input bit a1);
    rd_reg(a1);
    chk(tag, rd_val, a1 ? m_imr : (m_rd_isr ? m_isr : m_irr));
  endtask

  task automatic pulse(input int n);
    adv();
    irq[n] = 1'b1;
    adv();
    irq[n] = 1'b0;
    m_irr[n] = 1'b1;
  endtask

  task automatic settle_chk(input string tag);
    adv(); adv(); smp();
    chk(tag, {7'd0, int_o}, {7'd0, exp_int()});
  endtask

  task automatic inta_chk(input string tag);
    int p;
    logic [7:0] expv;
    p = lowest(m_irr & ~m_imr);
    expv = {m_vb, (p < 8) ? 3'(p) : 3'd7};
    if (p < 8) begin
      m_isr[p] = 1'b1;
      m_irr[p] = 1'b0;
    end
    adv(); ack = 1'b1; smp();
    chk({tag, "_sel"}, {7'd0, sel_o}, 8'h01);
    chk({tag, "_vec1"}, dout, expv);
    adv(); smp();
    chk({tag, "_int_drop"}, {7'd0, int_o}, 8'h00);
    adv(); ack = 1'b0;
    adv();
    adv(); ack = 1'b1; smp();
    chk({tag, "_vec"}, dout, expv);
    adv();
    adv(); ack = 1'b0;
    adv();
    adv();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    repeat (3) adv();
    rst_n = 1'b1;
    smp();

    // Reset state
    chk("rst_int",  {7'd0, int_o}, 8'h00);
    chk("rst_sel",  {7'd0, sel_o}, 8'h00);
    chk("rst_dbg",  {4'd0, dbg[3:0]}, 8'h00);
    read_chk("rst_imr", 1'b1);
    chk("rst_imr_n2", rd2_val, 8'hFC);
    read_chk("rst_irr", 1'b0);

    // Initialisation and basic priority
    wr_reg(1'b0, 8'h13);
    wr_reg(1'b1, 8'h08);
    wr_reg(1'b1, 8'h09);
    wr_reg(1'b1, 8'hFC);
    read_chk("init_imr", 1'b1);
    adv(); irq[0] = 1'b1; smp();
    chk("lat_n0", {7'd0, int_o}, 8'h00);
    adv(); irq[0] = 1'b0; smp();
    m_irr[0] = 1'b1;
    chk("lat_n1", {7'd0, int_o}, 8'h00);
    adv(); smp();
    chk("lat_n2", {7'd0, int_o}, 8'h01);
    inta_chk("irq0");
    wr_reg(1'b0, 8'h0B);
    read_chk("isr_after_irq0", 1'b0);

    // Nesting: lower priority blocked until EOI
    pulse(1);
    settle_chk("nest_blocked");
    wr_reg(1'b0, 8'h20);
    smp();
    chk("eoi_w1", {7'd0, int_o}, 8'h00);
    adv(); smp();
    chk("eoi_w2", {7'd0, int_o}, 8'h01);
    inta_chk("irq1");
    pulse(0);
    settle_chk("nest_preempt");
    inta_chk("irq0_nested");
    read_chk("isr_03", 1'b0);
    wr_reg(1'b0, 8'h61);
    read_chk("isr_spec_eoi", 1'b0);
    wr_reg(1'b0, 8'h20);
    read_chk("isr_ns_eoi", 1'b0);

    // Masking
    wr_reg(1'b1, 8'hFF);
    adv(); irq[1] = 1'b1; irq2[1] = 1'b1;
    adv(); irq[1] = 1'b0; irq2[1] = 1'b0;
    m_irr[1] = 1'b1;
    settle_chk("mask_noint");
    chk("mask_noint_n2", {7'd0, int2_o}, 8'h00);
    wr_reg(1'b0, 8'h0A);
    read_chk("mask_irr", 1'b0);
    chk("mask_irr_n2", rd2_val, 8'h02);
    wr_reg(1'b1, 8'hFD);
    smp();
    chk("unmask_w1", {7'd0, int_o}, 8'h00);
    adv(); smp();
    chk("unmask_w2", {7'd0, int_o}, 8'h01);
    chk("unmask_n2", {7'd0, int2_o}, 8'h01);
    read_chk("imr_fd", 1'b1);
    chk("imr_fd_n2", rd2_val, 8'hFD);
    inta_chk("irq1_unmasked");
    wr_reg(1'b0, 8'h20);

    // Spurious
    wr_reg(1'b1, 8'h00);
    pulse(4);
    settle_chk("spur_int");
    wr_reg(1'b1, 8'hFF);
    settle_chk("spur_masked");
    inta_chk("spur");
    wr_reg(1'b0, 8'h0B);
    read_chk("spur_isr", 1'b0);
    wr_reg(1'b1, 8'h00);
    settle_chk("spur_retained");
    inta_chk("irq4");
    wr_reg(1'b0, 8'h20);
    settle_chk("irq4_done");

    // Randomised operations against the model
    for (int it = 0; it < 80; it++) begin
      int op;
      op = $urandom_range(0, 5);
      case (op)
        0: pulse($urandom_range(0, 7));
        1: wr_reg(1'b1, 8'($urandom_range(0, 255) & $urandom_range(0, 255)));
        2: inta_chk("rnd_inta");
        3: wr_reg(1'b0, 8'h20);
        4: wr_reg(1'b0, 8'h60 | 8'($urandom_range(0, 7)));
        default: begin
          wr_reg(1'b0, $urandom_range(0, 1) ? 8'h0B : 8'h0A);
          read_chk("rnd_read", 1'($urandom_range(0, 1)));
        end
      endcase
      settle_chk("rnd_int");
    end

`ifdef PIC_LEVEL_TRIG_EN
    // Level mode: a withdrawn request yields the spurious vector
    wr_reg(1'b0, 8'h1B);
    wr_reg(1'b1, 8'h08);
    wr_reg(1'b1, 8'h09);
    wr_reg(1'b1, 8'h00);
    adv(); irq[2] = 1'b1; m_irr[2] = 1'b1;
    settle_chk("lvl_int");
    irq[2] = 1'b0; m_irr[2] = 1'b0;
    settle_chk("lvl_drop");
    inta_chk("lvl_spur");
`endif

    // Reset between INTA edges
    adv(); ack = 1'b1;
    adv();
    adv(); ack = 1'b0;
    adv(); rst_n = 1'b0;
    adv(); rst_n = 1'b1;
    model_reset();
    smp();
    chk("rst_mid_int", {7'd0, int_o}, 8'h00);
    chk("rst_mid_fsm", {6'd0, dbg[1:0]}, 8'h00);
    read_chk("rst_mid_imr", 1'b1);
    pulse(3);
    settle_chk("rst_mid_req");
    inta_chk("rst_mid_irq3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
